// File: rtl/teamd_incr_arbiter_if.sv
// Interface for the TEAMD incrementer arbiter: two requester channels and the result/ack path.
// The master modport is the client/consumer side, and the slave modport is the arbiter.
interface teamd_incr_arbiter_if #(
    parameter int unsigned WIDTH = 3
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             id;
    logic             valid;
    logic             ack;
    logic             busy;

    modport master (
        output req0, data0, req1, data1, ack,
        input  gnt0, gnt1, res, cout, id, valid, busy
    );

    modport slave (
        input  req0, data0, req1, data1, ack,
        output gnt0, gnt1, res, cout, id, valid, busy
    );
endinterface

// File: rtl/teamd_incr_arbiter.sv
// Round-robin arbiter sharing one ripple increment-by-one datapath between two requesters.
// Optional build macro TEAMD_INCR_SATURATE_EN: clamp RES to all-ones on carry-out instead of wrapping.
module teamd_incr_arbiter #(
    parameter int unsigned WIDTH         = 3,
    parameter bit          PRIORITY_INIT = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    teamd_incr_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Half-adder ripple chain with the carry-in tied to one.
    function automatic logic [WIDTH:0] f_incr(input logic [WIDTH-1:0] op);
        logic [WIDTH:0]   c;
        logic [WIDTH-1:0] s;
        c    = '0;
        s    = '0;
        c[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]     = op[i] ^ c[i];
            c[i + 1] = op[i] & c[i];
        end
        return {c[WIDTH], s};
    endfunction

    logic [1:0]       r_state;
    logic             r_ptr;
    logic [WIDTH-1:0] r_op;
    logic             r_gnt0;
    logic             r_gnt1;
    logic [WIDTH-1:0] r_res;
    logic             r_cout;
    logic             r_id;
    logic             r_valid;
    logic             r_busy;

    logic             w_any_req;
    logic             w_sel;
    logic [WIDTH-1:0] w_operand;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;

    // Requester selection: a lone request wins outright, a tie goes to the pointer.
    always_comb begin
        w_any_req = bus.req0 | bus.req1;
        w_sel     = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_sel = r_ptr;
        end else if (bus.req1) begin
            w_sel = 1'b1;
        end else begin
            w_sel = 1'b0;
        end
        w_operand = w_sel ? bus.data1 : bus.data0;
    end

    // Shared incrementer and the result shaping on carry-out.
    always_comb begin
        w_sum = f_incr(r_op);
`ifdef TEAMD_INCR_SATURATE_EN
        if (w_sum[WIDTH]) begin
            w_res = '1;
        end else begin
            w_res = w_sum[WIDTH-1:0];
        end
`else
        w_res = w_sum[WIDTH-1:0];
`endif
    end

    // Sequencing FSM; every output is a register so the consumer sees glitch-free handshakes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ptr   <= PRIORITY_INIT;
            r_op    <= '0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_id    <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_op    <= w_operand;
                        r_gnt0  <= ~w_sel;
                        r_gnt1  <= w_sel;
                        r_id    <= w_sel;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_res   <= w_res;
                    r_cout  <= w_sum[WIDTH];
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // Result is held until accepted; the loser of this round is favoured next.
                    if (bus.ack) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ptr   <= ~r_id;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0  = r_gnt0;
    assign bus.gnt1  = r_gnt1;
    assign bus.res   = r_res;
    assign bus.cout  = r_cout;
    assign bus.id    = r_id;
    assign bus.valid = r_valid;
    assign bus.busy  = r_busy;
endmodule

// File: doc/teamd_incr_arbiter.md
Name: teamd_incr_arbiter

Overview:
- Sequencing and arbitration controller that shares one WIDTH-bit increment-by-one datapath (half-adder ripple chain, constant-1 carry-in) between two requesters.
- Grants one request at a time with round-robin fairness, captures the operand, registers the sum and carry, and holds the result until the consumer acknowledges.
- Sits between two client blocks and the incrementer in the TEAMD arithmetic path.

Parameters:
- WIDTH, 3, operand/result width in bits; legal range 1..8.
- PRIORITY_INIT, 0, requester favoured on the first arbitration after reset (0 or 1).

Ports:
- CLK  input  1  single clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- REQ0  input  1  requester 0 request; held high until GNT0 is seen.
- DATA0  input  WIDTH  requester 0 operand; must be stable while REQ0 is high.
- REQ1  input  1  requester 1 request.
- DATA1  input  WIDTH  requester 1 operand.
- GNT0  output  1  one-cycle pulse: requester 0's operand captured.
- GNT1  output  1  one-cycle pulse: requester 1's operand captured.
- RES  output  WIDTH  DATA+1, modulo 2^WIDTH; valid while VALID is high.
- COUT  output  1  carry-out of the increment (operand was all-ones).
- ID  output  1  requester that owns RES.
- VALID  output  1  result available.
- ACK  input  1  consumer accepts the result; only meaningful while VALID is high.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RST=1):
  - State goes to IDLE.
  - GNT0=GNT1=0, VALID=0, BUSY=0, RES=0, COUT=0, ID=0.
  - Priority pointer is set to PRIORITY_INIT.
  - Takes effect immediately, mid-operation included: an in-flight result is discarded and not re-issued.
- FSM states: IDLE, CALC, DONE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one REQ high: grant that requester.
  - Both REQ high: grant the requester named by the priority pointer.
  - On a grant at edge n: the operand register loads the selected DATA; GNT for that requester is high during cycle n+1 only; ID is set; state goes to CALC.
- CALC (cycle n+1):
  - Operand drives the incrementer.
  - At edge n+1, {COUT,RES} load the (WIDTH+1)-bit sum.
  - State goes to DONE; VALID rises for cycle n+2.
- DONE:
  - VALID, RES, COUT and ID are held stable until ACK=1 is sampled.
  - At that edge: VALID falls, the priority pointer becomes the other requester (not ID), and state goes to IDLE.
- Latency and throughput:
  - Minimum latency from REQ sampled to VALID is 2 cycles.
  - With ACK tied high, a request is accepted at most every 3 cycles (IDLE, CALC, DONE).
- REQ handling:
  - A REQ that stays high after its GNT is treated as a new request once the FSM returns to IDLE.
  - Requesters must drop REQ on the cycle they see GNT if they want a single operation.
- ACK outside DONE is ignored.
- Wrap-around: operand all-ones gives RES=0 and COUT=1.
- Simultaneous ACK and new REQ:
  - ACK at edge m returns the FSM to IDLE.
  - The new REQ is arbitrated at edge m+1 using the already-updated pointer.
  - No request is lost.
- Requests arriving in CALC or DONE are not granted until IDLE. Clients wait with REQ held.

Optional Feature:
- Macro: TEAMD_INCR_SATURATE_EN.
- Defined: when the carry-out is 1, RES is forced to all-ones instead of wrapping to 0. COUT still reports 1.
- Undefined: RES wraps modulo 2^WIDTH as above.
- All other timing is identical in both builds.

Test Plan:
- Reset then REQ0=1, DATA0=3'b010, ACK tied 1 -> GNT0 pulses in cycle 1; VALID in cycle 2 with RES=3'b011, COUT=0, ID=0; BUSY low again in cycle 3.
- REQ0=REQ1=1 held, DATA0=5, DATA1=1, ACK=1, PRIORITY_INIT=0 -> results alternate: RES=6/ID=0, RES=2/ID=1, RES=6/ID=0; no requester is granted twice in a row.
- DATA1=3'b111 on requester 1 -> RES=3'b000, COUT=1. With TEAMD_INCR_SATURATE_EN defined: RES=3'b111, COUT=1.
- ACK held 0 for 5 cycles after VALID -> RES, COUT and ID stay stable, VALID stays high, no GNT issued while REQ1 waits; ACK=1 -> VALID drops, then GNT1 follows.
- RST asserted asynchronously mid-cycle during CALC -> VALID, BUSY and GNT go 0 immediately; after release, the first grant follows PRIORITY_INIT.
- ACK=1 in DONE with REQ1 asserted the same cycle -> FSM is in IDLE the next cycle and GNT1 pulses the cycle after that.
